// File: rtl/ecc_sed_pkg.sv
// Shared types and defaults for the single-error-detect encoder scheduler.
// No logic: state encoding, rsp_err bit positions, default parameters.
// Backpressure: n/a.
package ecc_sed_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_TIMEOUT    = 8;

    localparam int ERR_MISMATCH = 0;
    localparam int ERR_TIMEOUT  = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/ecc_sed_rr_arb.sv
// Round-robin selector: first asserted request at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; caller decides when the grant is consumed.
module ecc_sed_rr_arb #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] index,
    output logic           any
);

    logic [IDW-1:0] cand;

    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        cand  = '0;
        for (int off = 0; off < N; off++) begin
            cand = IDW'((int'(ptr) + off) % N);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                index       = cand;
            end
        end
    end

endmodule

// File: rtl/ecc_sed_enc_sched.sv
// Shares one SED encoder among NUM_REQ requesters, one transaction in flight.
// Latency: 3 cycles min request-to-response (accept, issue, encoder reply).
// Backpressure: response held until rsp_ready; no new accept until then.
module ecc_sed_enc_sched
    import ecc_sed_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          data_valid,
    output logic [DATA_WIDTH-1:0]         data,
    input  logic                          enc_valid,
    input  logic [DATA_WIDTH:0]           enc_codeword,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
    output logic [DATA_WIDTH:0]           rsp_codeword,
    output logic [1:0]                    rsp_err,
    output logic                          spurious
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    sched_state_t state, state_nxt;

    logic [IDW-1:0]        ptr;
    logic [IDW-1:0]        cur_id;
    logic [DATA_WIDTH-1:0] cap_data;
    logic [CW-1:0]         wait_cnt;

    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     grant_idx;
    logic               grant_any;
    logic               mismatch;
    logic               wait_expired;

    ecc_sed_rr_arb #(
        .N   (NUM_REQ),
        .IDW (IDW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .index (grant_idx),
        .any   (grant_any)
    );

    assign mismatch     = (enc_codeword[DATA_WIDTH-1:0] != cap_data) ||
                          (enc_codeword[DATA_WIDTH] != ^cap_data);
    assign wait_expired = (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // req_ready is gated by rst so a held request cannot leak a grant during reset.
    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        data_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (grant_any && rst) begin
                    req_ready = grant;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                data_valid = 1'b1;
                state_nxt  = S_WAIT;
            end
            S_WAIT: begin
                if (enc_valid || wait_expired) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr          <= '0;
            cur_id       <= '0;
            cap_data     <= '0;
            wait_cnt     <= '0;
            rsp_codeword <= '0;
            rsp_err      <= '0;
            spurious     <= 1'b0;
        end else begin
            spurious <= enc_valid && (state != S_WAIT);
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        cap_data <= req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                        cur_id   <= grant_idx;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    // A result arriving on the expiry cycle beats the timeout.
                    if (enc_valid) begin
                        rsp_codeword          <= enc_codeword;
                        rsp_err               <= '0;
                        rsp_err[ERR_MISMATCH] <= mismatch;
                    end else if (wait_expired) begin
                        rsp_codeword         <= '0;
                        rsp_err              <= '0;
                        rsp_err[ERR_TIMEOUT] <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        ptr <= (cur_id == IDW'(NUM_REQ - 1)) ? '0 : cur_id + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign data      = cap_data;
    assign rsp_valid = (state == S_RESP);
    assign rsp_id    = cur_id;

endmodule

// File: doc/ecc_sed_enc_sched.md
ECC_SED_ENC_SCHED -- requirements
Module: ecc_sed_enc_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one SED encoder.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, data word width; codeword width is DATA_WIDTH+1.
REQ-003 SHALL have parameter TIMEOUT, default 8, maximum WAIT cycles for enc_valid.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester request.
REQ-007 SHALL have port req_data  input  NUM_REQ*DATA_WIDTH  request data; requester i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port req_ready  output  NUM_REQ  one-hot accept pulse.
REQ-009 SHALL have port data_valid  output  1  one-cycle strobe to encoder.
REQ-010 SHALL have port data  output  DATA_WIDTH  word to encoder.
REQ-011 SHALL have port enc_valid  input  1  encoder result strobe.
REQ-012 SHALL have port enc_codeword  input  DATA_WIDTH+1  {parity, data} from encoder.
REQ-013 SHALL have port rsp_valid  output  1  response held until accepted.
REQ-014 SHALL have port rsp_ready  input  1  response accept.
REQ-015 SHALL have port rsp_id  output  $clog2(NUM_REQ)  requester index of response.
REQ-016 SHALL have port rsp_codeword  output  DATA_WIDTH+1  captured codeword.
REQ-017 SHALL have port rsp_err  output  2  bit0 = codeword mismatch, bit1 = timeout.
REQ-018 SHALL have port spurious  output  1  one-cycle pulse on enc_valid outside WAIT.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; one transaction in flight.
REQ-020 IDLE: if any req_valid, SHALL select requester by round-robin starting at pointer ptr, pulse req_ready[grant] that cycle, capture its data, go to ISSUE; else stay.
REQ-021 ISSUE: SHALL drive data_valid=1 with captured data for exactly one cycle, clear wait counter, go to WAIT.
REQ-022 WAIT: on enc_valid SHALL capture enc_codeword, compute rsp_err[0], go to RESP.
REQ-023 rsp_err[0] SHALL be 1 when enc_codeword[DATA_WIDTH-1:0] != captured data or enc_codeword[DATA_WIDTH] != XOR-reduce of captured data (even parity).
REQ-024 WAIT: if TIMEOUT cycles elapse without enc_valid, SHALL go to RESP with rsp_err=2'b10 and rsp_codeword=0.
REQ-025 RESP: SHALL assert rsp_valid with stable rsp_id/rsp_codeword/rsp_err until rsp_ready; on rsp_valid&&rsp_ready SHALL set ptr=(grant+1) mod NUM_REQ and go to IDLE.
REQ-026 enc_valid in IDLE, ISSUE or RESP SHALL be ignored for data and SHALL pulse spurious the next cycle.
REQ-027 enc_valid on the same cycle the timeout count expires SHALL be taken as a valid result (result wins).
REQ-028 Pointer wrap: grant NUM_REQ-1 SHALL set ptr=0.
REQ-029 req_ready SHALL be 0 in all states except the IDLE accept cycle; data_valid SHALL be 0 outside ISSUE.
REQ-030 Minimum request-to-response latency SHALL be 3 cycles (accept, ISSUE, WAIT with enc_valid on its first cycle, rsp_valid next).

Reset
REQ-031 On rst low, SHALL asynchronously enter IDLE, ptr=0, wait counter=0.
REQ-032 During reset, req_ready=0, data_valid=0, data=0, rsp_valid=0, rsp_id=0, rsp_codeword=0, rsp_err=0, spurious=0.
REQ-033 Reset mid-transaction SHALL drop the transaction with no response.

Structure
REQ-034 FSM state enum, rsp_err bit positions and default parameters SHALL reside in shared package ecc_sed_pkg.
REQ-035 Round-robin selection SHALL be one sub-module ecc_sed_rr_arb (inputs req, ptr; outputs one-hot grant, index, any).

Verification
REQ-036 Single req_valid[2], data 8'hA5, encoder returns 9'h0A5 after 1 cycle -> rsp_id=2, rsp_codeword=9'h0A5, rsp_err=0, rsp_valid at cycle 3.
REQ-037 All four req_valid held high, ptr=0 -> grants 0,1,2,3,0 in order.
REQ-038 Data 8'h01, encoder returns 9'h001 (bad parity) -> rsp_err=2'b01.
REQ-039 No enc_valid after ISSUE -> after 8 WAIT cycles rsp_err=2'b10, rsp_codeword=0.
REQ-040 enc_valid pulsed in IDLE -> spurious pulses once, no rsp_valid.
REQ-041 rst low during WAIT, then release -> IDLE, no rsp_valid, next grant from requester 0.
